// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: one outstanding imem read feeding a DEPTH-entry FIFO of {pc, word}.
// Define PREFETCH_STATS_EN to build the saturating flush_count of discarded instructions.
module prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic [3:0]  occupancy,
  output logic [15:0] flush_count
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t        r_state, w_state_next;
  logic [31:0]   r_fetch_pc, w_fetch_pc_next;
  logic [31:0]   r_req_addr, w_req_addr_next;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [3:0]    r_count, w_count_after;
  logic [31:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic          w_push, w_pop, w_valid;

  assign w_valid       = (r_count != 4'd0);
  assign w_pop         = w_valid & inst_ready & ~redirect;
  assign w_count_after = r_count + 4'd1 - {3'b000, w_pop};

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_req_addr_next = r_req_addr;
    w_push          = 1'b0;
    imem_req        = 1'b0;
    imem_addr       = r_req_addr;
    case (r_state)
      S_IDLE: begin
        imem_addr = r_fetch_pc;
        if (redirect) begin
          w_fetch_pc_next = redirect_pc;
        end else if (r_count < DEPTH_C) begin
          imem_req        = 1'b1;
          w_state_next    = S_WAIT;
          w_req_addr_next = r_fetch_pc;
        end
      end
      S_WAIT: begin
        imem_req = 1'b1;
        if (redirect) begin
          w_fetch_pc_next = redirect_pc;
          w_state_next    = imem_ack ? S_IDLE : S_DROP;
        end else if (imem_ack) begin
          w_push          = 1'b1;
          w_fetch_pc_next = r_fetch_pc + 32'd4;
          // Chain the next request straight from WAIT when the FIFO still has room.
          if (w_count_after < DEPTH_C) begin
            w_state_next    = S_WAIT;
            w_req_addr_next = r_fetch_pc + 32'd4;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_DROP: begin
        imem_req = 1'b1;
        if (redirect) begin
          w_fetch_pc_next = redirect_pc;
        end
        if (imem_ack) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (reset) begin
      imem_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= 4'd0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_req_addr <= w_req_addr_next;
      if (redirect) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= 4'd0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        r_count <= r_count + {3'b000, w_push} - {3'b000, w_pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
      r_mem_data[r_wr_ptr] <= imem_rdata;
    end
  end

  assign inst_valid = w_valid;
  assign inst_out   = w_valid ? r_mem_data[r_rd_ptr] : 32'h0;
  assign inst_pc    = w_valid ? r_mem_pc[r_rd_ptr] : 32'h0;
  assign occupancy  = r_count;

`ifdef PREFETCH_STATS_EN
  logic [15:0] r_flush_count;
  logic [16:0] w_flush_sum;

  // An outstanding request at redirect time is always thrown away, now or on its late ack.
  assign w_flush_sum = {1'b0, r_flush_count} + 17'(r_count) + 17'(r_state == S_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush_count <= 16'h0;
    end else if (redirect) begin
      r_flush_count <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
    end
  end

  assign flush_count = r_flush_count;
`else
  assign flush_count = 16'h0;
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// Scoreboard bench for prefetch_queue: a memory responder, directed scenarios, then random
// ready/redirect/reset traffic; a monitor compares every accepted instruction to the model.
module tb_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PREFETCH_STATS_EN
  localparam logic [31:0] EXP_FLUSH = 32'd4;
`else
  localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_ready = 1'b1;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [3:0]  occupancy;
  logic [15:0] flush_count;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  // Expected instruction stream: consecutive addresses from the last reset/redirect target.
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  // Memory responder controls
  bit          hold = 1'b0;
  bit          ack_now = 1'b0;
  bit          stray_ack = 1'b0;
  bit          force_en = 1'b0;
  logic [31:0] force_val = 32'h0;
  int unsigned lat_max = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int unsigned wait_cnt = 0;

  prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_ready (inst_ready),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .occupancy  (occupancy),
    .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(pc + 32'(i * 4));
  endtask

  // what: 0 = imem_req, 1 = occupancy == val, other = inst_valid
  task automatic wait_for(input string name, input int what, input logic [3:0] val);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 40 && !hit; n++) begin
      @(negedge clk);
      case (what)
        0:       hit = imem_req;
        1:       hit = (occupancy == val);
        default: hit = inst_valid;
      endcase
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL %s: condition not reached, required within 40 cycles", name);
    end
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    redirect = 1'b0;
    refill(RESET_PC);
    step();
    @(negedge clk);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_out", inst_out, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_flush", 32'(flush_count), 32'd0);
    step();
    reset = 1'b0;
    stray_ack = 1'b1;
  endtask

  // Memory: acks a captured request after 0..lat_max extra cycles and checks it is held stable.
  initial begin : responder
    bit acked;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      acked      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      if (stray_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        stray_ack  = 1'b0;
      end else if (pend && !hold && (wait_cnt == 0 || ack_now)) begin
        imem_ack   = 1'b1;
        imem_rdata = force_en ? force_val : mem_word(pend_addr);
        force_en   = 1'b0;
        pend       = 1'b0;
        acked      = 1'b1;
      end else if (pend && !hold) begin
        wait_cnt--;
      end
      ack_now = 1'b0;
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
      end else if (pend) begin
        check("req_held", 32'(imem_req), 32'd1);
        check("addr_held", imem_addr, pend_addr);
      end else if (imem_req && !acked) begin
        pend      = 1'b1;
        pend_addr = imem_addr;
        wait_cnt  = $urandom_range(lat_max, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && inst_valid && inst_ready && !redirect) begin
      pops++;
      $display("pop pc=%h data=%h occ=%0d", inst_pc, inst_out, occupancy);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: got pop pc=%h, required no pop", inst_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        check("pop_pc", inst_pc, exp_pc);
        check("pop_data", inst_out, mem_word(exp_pc));
`ifndef PREFETCH_STATS_EN
        check("flush_zero", 32'(flush_count), 32'd0);
`endif
      end
    end
  end

  initial begin : stim
    logic [31:0] old_addr;
    logic [31:0] tmp;
    int          pops0;
    int          since;

    // Reset, first-fetch latency and the 0,4,8,12 stream (stray ack right after reset)
    inst_ready = 1'b1;
    lat_max    = 0;
    do_reset();
    @(negedge clk);
    check("lat_c0_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    check("lat_c1_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    check("lat_c2_valid", 32'(inst_valid), 32'd1);
    check("lat_c2_pc", inst_pc, 32'h0);
    repeat (8) step();

    // Consumer stall: FIFO fills, fetch stops, then drains in order
    inst_ready = 1'b0;
    repeat (12) step();
    @(negedge clk);
    check("full_occ", 32'(occupancy), 32'(DEPTH));
    check("full_req", 32'(imem_req), 32'd0);
    step();
    inst_ready = 1'b1;
    repeat (12) step();

    // Redirect while waiting; the late ack carries DEAD and must be dropped
    hold = 1'b1;
    wait_for("drop_wait_req", 0, 4'd0);
    old_addr = imem_addr;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    refill(32'h0000_0100);
    step();
    redirect = 1'b0;
    @(negedge clk);
    check("drop_req", 32'(imem_req), 32'd1);
    check("drop_addr", imem_addr, old_addr);
    check("drop_occ", 32'(occupancy), 32'd0);
    step();
    force_val = 32'h0000_DEAD;
    force_en  = 1'b1;
    ack_now   = 1'b1;
    hold      = 1'b0;
    wait_for("drop_first_valid", 2, 4'd0);
    check("drop_next_pc", inst_pc, 32'h0000_0100);
    check("drop_next_data", inst_out, mem_word(32'h0000_0100));

    // Redirect coinciding with an ack and a pop
    step();
    inst_ready = 1'b0;
    wait_for("coinc_fill", 1, 4'd2);
    hold = 1'b1;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    refill(32'h0000_0200);
    inst_ready  = 1'b1;
    ack_now     = 1'b1;
    hold        = 1'b0;
    @(negedge clk);
    check("coinc_ack", 32'(imem_ack), 32'd1);
    check("coinc_valid", 32'(inst_valid), 32'd1);
    step();
    redirect = 1'b0;
    @(negedge clk);
    check("coinc_occ", 32'(occupancy), 32'd0);
    check("coinc_inst_valid", 32'(inst_valid), 32'd0);
    check("coinc_req", 32'(imem_req), 32'd1);
    check("coinc_addr", imem_addr, 32'h0000_0200);

    // Fetch address wraps past the top of the address space
    step();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    refill(32'hFFFF_FFF8);
    pops0 = pops;
    step();
    redirect = 1'b0;
    repeat (12) step();
    check("wrap_pops", 32'((pops - pops0) >= 3), 32'd1);

    // Redirect with three queued entries and one in flight
    inst_ready = 1'b0;
    do_reset();
    wait_for("stats_fill", 1, 4'd3);
    hold = 1'b1;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0400;
    refill(32'h0000_0400);
    step();
    redirect   = 1'b0;
    hold       = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    check("flush_count", 32'(flush_count), EXP_FLUSH);

    // Random traffic
    lat_max = 3;
    since   = 0;
    for (int i = 0; i < 1500; i++) begin
      step();
      redirect   = 1'b0;
      reset      = 1'b0;
      inst_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(299, 0) == 0) begin
        reset = 1'b1;
        refill(RESET_PC);
        since = 0;
      end else if (since > 120 || $urandom_range(19, 0) == 0) begin
        tmp = $urandom();
        tmp[1:0] = 2'b00;
        if ($urandom_range(3, 0) == 0) tmp = 32'hFFFF_FFF0;
        redirect    = 1'b1;
        redirect_pc = tmp;
        refill(tmp);
        since = 0;
      end else begin
        since++;
      end
    end
    step();
    redirect   = 1'b0;
    reset      = 1'b0;
    inst_ready = 1'b1;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run still active at 500000, required to finish earlier");
    $fatal(1, "timeout");
  end

endmodule
